// File: rtl/serial_arith_unit.sv
// Digit-serial add/subtract unit: one DIGIT-bit adder plus a carry register walks
// WIDTH-bit operands LSB-first, with a start/busy/done handshake and result flags.
module serial_arith_unit #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic [1:0]       S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Cout,
    output logic             V,
    output logic             Z
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
            $error("serial_arith_unit: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   x_q;
    logic [WIDTH-1:0]   res_q;
    logic               carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               amsb_q;
    logic               xmsb_q;
    logic               busy_q;
    logic               done_q;
    logic [WIDTH-1:0]   d_q;
    logic               cout_q;
    logic               v_q;
    logic               z_q;

    logic [WIDTH-1:0]       x_sel_d;
    logic [DIGIT:0]         sum_d;
    logic [WIDTH+DIGIT-1:0] cat_d;
    logic [WIDTH-1:0]       res_d;

    always_comb begin
        case (S)
            2'b00:   x_sel_d = B;
            2'b01:   x_sel_d = ~B;
            2'b10:   x_sel_d = '0;
            default: x_sel_d = '1;
        endcase
        sum_d = {1'b0, a_q[DIGIT-1:0]} + {1'b0, x_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};
        // New digit enters at the MSB end; after N shifts the first digit sits at the LSB.
        cat_d = {sum_d[DIGIT-1:0], res_q} >> DIGIT;
        res_d = cat_d[WIDTH-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            x_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            amsb_q  <= 1'b0;
            xmsb_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_q     <= '0;
            cout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_q     <= A;
                        x_q     <= x_sel_d;
                        carry_q <= Cin;
                        cnt_q   <= '0;
                        res_q   <= '0;
                        amsb_q  <= A[WIDTH-1];
                        xmsb_q  <= x_sel_d[WIDTH-1];
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    a_q     <= a_q >> DIGIT;
                    x_q     <= x_q >> DIGIT;
                    carry_q <= sum_d[DIGIT];
                    res_q   <= res_d;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(N - 1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        d_q     <= res_d;
                        cout_q  <= sum_d[DIGIT];
                        v_q     <= (amsb_q == xmsb_q) && (res_d[WIDTH-1] != amsb_q);
                        z_q     <= (res_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign D    = d_q;
    assign Cout = cout_q;
    assign V    = v_q;
    assign Z    = z_q;

endmodule

// File: tb/tb_serial_arith_unit.sv
// Scoreboard bench for serial_arith_unit: a bit-serial instance (DIGIT=1) and a
// radix-16 instance (DIGIT=4), both WIDTH=8, checked against a parallel adder model.
module tb_serial_arith_unit;

    localparam int N1 = 8;
    localparam int N2 = 2;

    typedef struct {
        logic [7:0] d;
        logic       cout;
        logic       v;
        logic       z;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [7:0] A1 = '0, B1 = '0, A2 = '0, B2 = '0;
    logic       Cin1 = 1'b0, Cin2 = 1'b0;
    logic [1:0] S1 = '0, S2 = '0;
    logic       busy1, done1, Cout1, V1, Z1;
    logic       busy2, done2, Cout2, V2, Z2;
    logic [7:0] D1, D2;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t q1[$];
    exp_t q2[$];
    exp_t e1, e2;
    logic [7:0] hold1 = '0, hold2 = '0;

    serial_arith_unit #(.WIDTH(8), .DIGIT(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .Cin(Cin1), .S(S1),
        .busy(busy1), .done(done1), .D(D1), .Cout(Cout1), .V(V1), .Z(Z1)
    );

    serial_arith_unit #(.WIDTH(8), .DIGIT(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start2), .A(A2), .B(B2), .Cin(Cin2), .S(S2),
        .busy(busy2), .done(done2), .D(D2), .Cout(Cout2), .V(V2), .Z(Z2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic [1:0] s, input logic cin, input int c);
        exp_t       e;
        logic [7:0] x;
        logic [8:0] sum;
        case (s)
            2'd0:    x = b;
            2'd1:    x = ~b;
            2'd2:    x = 8'h00;
            default: x = 8'hFF;
        endcase
        sum    = {1'b0, a} + {1'b0, x} + {8'b0, cin};
        e.d    = sum[7:0];
        e.cout = sum[8];
        e.v    = (a[7] == x[7]) && (sum[7] != a[7]);
        e.z    = (sum[7:0] == 8'h00);
        e.cyc  = c;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done1 !== 1'b0) begin
            if (q1.size() == 0) begin
                chk("dut1_unexpected_done", 32'(done1), 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk("dut1_D", 32'(D1), 32'(e1.d));
                chk("dut1_Cout", 32'(Cout1), 32'(e1.cout));
                chk("dut1_V", 32'(V1), 32'(e1.v));
                chk("dut1_Z", 32'(Z1), 32'(e1.z));
                chk("dut1_latency", 32'(cyc), 32'(e1.cyc));
                hold1 = e1.d;
            end
        end
        if (done2 !== 1'b0) begin
            if (q2.size() == 0) begin
                chk("dut4_unexpected_done", 32'(done2), 32'd0);
            end else begin
                e2 = q2.pop_front();
                chk("dut4_D", 32'(D2), 32'(e2.d));
                chk("dut4_Cout", 32'(Cout2), 32'(e2.cout));
                chk("dut4_V", 32'(V2), 32'(e2.v));
                chk("dut4_Z", 32'(Z2), 32'(e2.z));
                chk("dut4_latency", 32'(cyc), 32'(e2.cyc));
                hold2 = e2.d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // stress: scramble inputs every RUN cycle and raise a stray start in cycle 4
    task automatic run1(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        input logic cin, input bit stress);
        A1 = a; B1 = b; S1 = s; Cin1 = cin; start1 = 1'b1;
        q1.push_back(model(a, b, s, cin, cyc + N1 + 1));
        tick();
        start1 = 1'b0;
        for (int i = 1; i <= N1; i++) begin
            chk("dut1_busy", 32'(busy1), 32'd1);
            chk("dut1_hold_D", 32'(D1), 32'(hold1));
            if (stress) begin
                A1 = 8'($urandom); B1 = 8'($urandom); S1 = 2'($urandom); Cin1 = 1'($urandom);
                start1 = (i == 4);
            end
            tick();
        end
        start1 = 1'b0;
        chk("dut1_busy_end", 32'(busy1), 32'd0);
    endtask

    task automatic run2(input logic [7:0] a, input logic [7:0] b, input logic [1:0] s,
                        input logic cin);
        A2 = a; B2 = b; S2 = s; Cin2 = cin; start2 = 1'b1;
        q2.push_back(model(a, b, s, cin, cyc + N2 + 1));
        tick();
        start2 = 1'b0;
        for (int i = 1; i <= N2; i++) begin
            chk("dut4_busy", 32'(busy2), 32'd1);
            chk("dut4_hold_D", 32'(D2), 32'(hold2));
            tick();
        end
        chk("dut4_busy_end", 32'(busy2), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        tick(); tick(); tick();
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_done", 32'(done1), 32'd0);
        chk("rst_D", 32'(D1), 32'd0);
        chk("rst_flags", 32'({Cout1, V1, Z1}), 32'd0);
        chk("rst_dut4_outs", 32'({busy2, done2, D2, Cout2, V2, Z2}), 32'd0);
        rst = 1'b0;
        tick();

        // 0x5A+0x3C with scrambled inputs and an ignored start, then back-to-back ops
        run1(8'h5A, 8'h3C, 2'd0, 1'b0, 1'b1);
        run1(8'h7F, 8'h55, 2'd2, 1'b1, 1'b0);
        run1(8'h00, 8'hA5, 2'd3, 1'b0, 1'b0);
        run1(8'h10, 8'h10, 2'd1, 1'b1, 1'b0);
        for (int k = 0; k < 6; k++)
            run1(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), k == 2);
        run1(8'h80, 8'h80, 2'd0, 1'b0, 1'b0);
        run1(8'h00, 8'h00, 2'd3, 1'b0, 1'b0);
        tick(); tick();

        run2(8'h10, 8'h10, 2'd1, 1'b1);
        run2(8'h5A, 8'h3C, 2'd0, 1'b0);
        for (int k = 0; k < 4; k++)
            run2(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom));
        tick(); tick();

        // abort in RUN cycle 3; the DUT must clear without waiting for a clock edge
        A1 = 8'h33; B1 = 8'h44; S1 = 2'd0; Cin1 = 1'b0; start1 = 1'b1;
        tick();
        start1 = 1'b0;
        tick(); tick();
        #2 rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_done", 32'(done1), 32'd0);
        chk("abort_D", 32'(D1), 32'd0);
        chk("abort_flags", 32'({Cout1, V1, Z1}), 32'd0);
        hold1 = 8'h00;
        hold2 = 8'h00;
        tick(); tick();
        rst = 1'b0;
        tick();
        run1(8'hC8, 8'h64, 2'd0, 1'b1, 1'b0);
        run1(8'h01, 8'h02, 2'd1, 1'b1, 1'b0);
        tick(); tick(); tick();

        chk("dut1_queue_drained", 32'(q1.size()), 32'd0);
        chk("dut4_queue_drained", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
